// File: rtl/qpp_interleave_buffer_if.sv
// rtl/qpp_interleave_buffer_if.sv - handshake bundle between the interleave buffer and its neighbours
//
// Purpose: groups the sample input stream, the QPP generator link, the
// interleaved output stream and the status flags of qpp_interleave_buffer.
// Signals:
//   n_len     block length N, sampled on the first accepted sample
//   in_data   natural-order sample;   in_valid / in_ready handshake
//   gen_init  one-cycle init pulse to the address generator
//   pi_in     generator pi(x) address, one per clock after init
//   out_data  interleaved sample;     out_valid / out_last (no backpressure)
//   busy, cfg_err, addr_err  status
// Modports: master = block feeding / observing the buffer, slave = the buffer.
interface qpp_interleave_buffer_if #(
  parameter int DW = 8,
  parameter int AW = 16
);
  logic [AW-1:0] n_len;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          gen_init;
  logic [AW-1:0] pi_in;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          cfg_err;
  logic          addr_err;

  modport master (
    output n_len, in_data, in_valid, pi_in,
    input  in_ready, gen_init, out_data, out_valid, out_last, busy, cfg_err, addr_err
  );

  modport slave (
    input  n_len, in_data, in_valid, pi_in,
    output in_ready, gen_init, out_data, out_valid, out_last, busy, cfg_err, addr_err
  );
endinterface

// File: rtl/qpp_interleave_buffer.sv
// rtl/qpp_interleave_buffer.sv - block buffer that re-reads samples in QPP pi(x) order
//
// Purpose: accepts a block of N samples in natural order, pulses the QPP
// generator's init, then reads the buffer back at the generator's pi(x)
// sequence and emits the interleaved block.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high
//   bus   qpp_interleave_buffer_if.slave (sample in, generator link, sample out, status)
module qpp_interleave_buffer #(
  parameter int DW      = 8,
  parameter int AW      = 16,
  parameter int MAX_N   = 6144,
  parameter int GEN_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  qpp_interleave_buffer_if.slave   bus
);

  localparam int RAM_AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [AW-1:0] MAX_N_W   = AW'(MAX_N);
  localparam logic [AW-1:0] ONE       = AW'(1);
  // WAIT is entered with GEN_LAT-1 and left when the count reaches one, so
  // DRAIN starts exactly GEN_LAT clocks after the init pulse.
  localparam logic [AW-1:0] WAIT_INIT = AW'(GEN_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    PRIME = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4,
    FLUSH = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]     n_reg;
  logic [AW-1:0]     wcnt;
  logic [AW-1:0]     rcnt;
  logic [AW-1:0]     wait_cnt;
  logic [DW-1:0]     ram [0:MAX_N-1];

  logic              n_legal;
  logic              accept;
  logic              last_wr;
  logic              last_rd;
  logic              rd_oob;
  logic [RAM_AW-1:0] wr_addr;
  logic [RAM_AW-1:0] rd_addr;

  assign n_legal = (bus.n_len != '0) && (bus.n_len <= MAX_N_W);
  assign accept  = bus.in_valid && bus.in_ready;
  assign last_wr = (wcnt == n_reg - ONE);
  assign last_rd = (rcnt == n_reg - ONE);
  assign rd_oob  = (bus.pi_in >= n_reg);

  // The first sample of a block always lands at 0; wcnt still holds the
  // previous block's count while IDLE.
  assign wr_addr = (state == IDLE) ? '0 : wcnt[RAM_AW-1:0];
  // Out-of-range generator addresses are redirected to entry 0 so the read
  // never leaves the buffer.
  assign rd_addr = rd_oob ? '0 : bus.pi_in[RAM_AW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.n_len == ONE) ? PRIME : FILL;
      FILL:    if (accept && last_wr) state_nxt = PRIME;
      PRIME:   state_nxt = (GEN_LAT == 1) ? DRAIN : WAIT;
      WAIT:    if (wait_cnt <= ONE) state_nxt = DRAIN;
      DRAIN:   if (last_rd) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.in_ready = 1'b0;
    bus.gen_init = 1'b0;
    bus.cfg_err  = 1'b0;
    bus.busy     = (state != IDLE);
    case (state)
      IDLE: begin
        // Held low during reset so nothing looks accepted while rst is high.
        bus.in_ready = n_legal && !rst;
        bus.cfg_err  = !n_legal;
      end
      FILL:    bus.in_ready = 1'b1;
      PRIME:   bus.gen_init = 1'b1;
      default: ;
    endcase
  end

  // Sample buffer write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (accept) ram[wr_addr] <= bus.in_data;
  end

  // Counters, error flag and registered read port / output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg         <= '0;
      wcnt          <= '0;
      rcnt          <= '0;
      wait_cnt      <= '0;
      bus.addr_err  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          n_reg        <= bus.n_len;
          wcnt         <= ONE;
          bus.addr_err <= 1'b0;
        end
        FILL:  if (accept) wcnt <= wcnt + ONE;
        PRIME: begin
          rcnt     <= '0;
          wait_cnt <= WAIT_INIT;
        end
        WAIT:  wait_cnt <= wait_cnt - ONE;
        DRAIN: begin
          rcnt <= rcnt + ONE;
          if (rd_oob) bus.addr_err <= 1'b1;
        end
        default: ;
      endcase

      bus.out_valid <= (state == DRAIN);
      bus.out_last  <= (state == DRAIN) && last_rd;
      if (state == DRAIN) bus.out_data <= ram[rd_addr];
    end
  end

endmodule

// File: tb/tb_qpp_interleave_buffer.sv
// tb/tb_qpp_interleave_buffer.sv - directed self-checking bench for qpp_interleave_buffer
//
// Purpose: drives sample blocks, models the QPP address generator
// (pi_x0=0, gamma_x0=13, g=20 for f1=3, f2=10), and checks the interleaved
// output stream and status flags against hand-derived expectations.
module tb_qpp_interleave_buffer;

  localparam int DW      = 8;
  localparam int AW      = 16;
  localparam int MAX_N   = 6144;
  localparam int GEN_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qpp_interleave_buffer_if #(.DW(DW), .AW(AW)) bus ();

  qpp_interleave_buffer #(
    .DW(DW), .AW(AW), .MAX_N(MAX_N), .GEN_LAT(GEN_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Generator model: 0 = QPP recursion, 1 = identity, 2 = QPP with pi=45 forced at x=5
  int gen_mode = 0;
  int gen_n    = 40;
  int gx       = 0;
  int gpi      = 0;
  int ggam     = 13;
  int gen_cnt  = 0;

  always @(posedge clk) begin
    if (bus.gen_init) begin
      gx   <= 0;
      gpi  <= 0;
      ggam <= 13;
    end else begin
      gx   <= gx + 1;
      gpi  <= (gpi + ggam) % gen_n;
      ggam <= (ggam + 20) % gen_n;
    end
    if (bus.gen_init) gen_cnt <= gen_cnt + 1;
  end

  assign bus.pi_in = (gen_mode == 2 && gx == 5) ? 16'd45 :
                     (gen_mode == 1)            ? gx[15:0] : gpi[15:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_data(input int mode, input int k, input int base);
    int p;
    if (mode == 1)                p = k;
    else if (mode == 2 && k == 5) p = 0;
    else                          p = (3 * k + 10 * k * k) % 40;
    return (p + base) & 'hFF;
  endfunction

  // Returns positioned just after the edge that entered PRIME.
  task automatic send_block(input int n, input bit toggle, input int base);
    int  sent = 0;
    int  cyc  = 0;
    bit  acc;
    bus.n_len = AW'(n);
    @(posedge clk); #1;
    while (sent < n && cyc < 4 * n + 8) begin
      bus.in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.in_data  = DW'(sent + base);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent == 1) chk("addr_err_clear_on_start", bus.addr_err, 0);
      end
    end
    bus.in_valid = 1'b0;
    chk("fill_accept_count", sent, n);
  endtask

  // Starts in the PRIME cycle; ends at the negedge of the first IDLE cycle.
  task automatic drain(input int n, input int mode, input int base);
    @(negedge clk);
    chk("prime_gen_init", bus.gen_init, 1);
    chk("prime_in_ready", bus.in_ready, 0);
    chk("prime_busy", bus.busy, 1);
    @(negedge clk);
    chk("drain0_no_output_yet", bus.out_valid, 0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("out_valid[%0d]", k), bus.out_valid, 1);
      chk($sformatf("out_data[%0d]", k), bus.out_data, exp_data(mode, k, base));
      chk($sformatf("out_last[%0d]", k), bus.out_last, (k == n - 1));
      if (k == n - 1) chk("flush_busy", bus.busy, 1);
    end
    @(negedge clk);
    chk("after_flush_out_valid", bus.out_valid, 0);
    chk("after_flush_busy", bus.busy, 0);
  endtask

  initial begin
    int g0;
    rst          = 1'b1;
    bus.n_len    = '0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_gen_init", bus.gen_init, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_addr_err", bus.addr_err, 0);
    chk("rst_out_data", bus.out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // N=40 QPP block, contiguous input
    gen_mode = 0; gen_n = 40;
    send_block(40, 1'b0, 0);
    drain(40, 0, 0);

    // Same block with in_valid toggling; one init pulse after the last accept
    g0 = gen_cnt;
    send_block(40, 1'b1, 0);
    chk("toggle_no_early_init", gen_cnt, g0);
    drain(40, 0, 0);
    chk("toggle_single_init", gen_cnt, g0 + 1);

    // N=1, identity generator
    gen_mode = 1;
    send_block(1, 1'b0, 'hA5);
    drain(1, 1, 'hA5);

    // Illegal lengths in IDLE
    @(posedge clk); #1;
    bus.n_len = 16'd0; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("len0_cfg_err", bus.cfg_err, 1);
    chk("len0_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("len0_stays_idle", bus.busy, 0);
    bus.n_len = 16'd6145;
    @(negedge clk);
    chk("len6145_cfg_err", bus.cfg_err, 1);
    chk("len6145_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("len6145_stays_idle", bus.busy, 0);
    chk("len6145_no_output", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    bus.n_len = 16'd6144;
    @(negedge clk);
    chk("len6144_cfg_err", bus.cfg_err, 0);
    chk("len6144_in_ready", bus.in_ready, 1);

    // Maximum block, identity generator
    send_block(6144, 1'b0, 0);
    drain(6144, 1, 0);

    // Out-of-range address injected at k=5
    gen_mode = 2; gen_n = 40;
    send_block(40, 1'b0, 0);
    drain(40, 2, 0);
    chk("addr_err_set", bus.addr_err, 1);
    repeat (3) @(negedge clk);
    chk("addr_err_sticky_idle", bus.addr_err, 1);
    gen_mode = 0;
    send_block(40, 1'b0, 0);
    drain(40, 0, 0);
    chk("addr_err_clean_block", bus.addr_err, 0);

    // Reset in the middle of DRAIN (k=20), then a clean block
    send_block(40, 1'b0, 0);
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_drain_out_valid", bus.out_valid, 1);
    chk("mid_drain_out_data", bus.out_data, exp_data(0, 19, 0));
    @(negedge clk);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_out_last", bus.out_last, 0);
    chk("post_rst_gen_init", bus.gen_init, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_block(40, 1'b0, 0);
    drain(40, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qpp_interleave_buffer.md
Name: qpp_interleave_buffer

Overview:
Downstream consumer of the QPP address generator. Accepts a block of N samples in natural order into an internal buffer. It then pulses the generator's init input and reads the buffer back at the generator's pi(x) sequence, one address per clock, emitting the interleaved block. Sits between the turbo-encoder input framing and constituent encoder 2.

Parameters:
DW, 8, sample data width
AW, 16, address width; matches the generator's 16-bit pi bus
MAX_N, 6144, buffer depth and largest legal block length
GEN_LAT, 1, clocks from gen_init high to pi(0) valid on pi_in (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
n_len  in  AW  block length N; sampled on first accepted sample of a block
in_data  in  DW  natural-order sample
in_valid  in  1  in_data valid
in_ready  out  1  block accepts a sample this cycle
gen_init  out  1  one-cycle init pulse to the generator's int input
pi_in  in  AW  generator pi_x1 output, one new address per clock after init
out_data  out  DW  interleaved sample
out_valid  out  1  out_data valid; no backpressure
out_last  out  1  marks final sample of block (with out_valid)
busy  out  1  high in any state other than IDLE
cfg_err  out  1  n_len illegal while IDLE (0 or >MAX_N)
addr_err  out  1  sticky: some pi_in >= latched N during drain

Behaviour:
- Reset: state IDLE; in_ready, gen_init, out_valid, out_last, busy, addr_err = 0; out_data = 0; counters cleared. RAM is not cleared.
- Buffer: single-port-per-side RAM, MAX_N x DW, one write port, one read port, 1-clock read latency.
- States: IDLE, FILL, PRIME, WAIT, DRAIN, FLUSH.
- IDLE:
  - in_ready = 1 iff 1 <= n_len <= MAX_N; cfg_err = !that.
  - On in_valid&&in_ready: latch n_reg = n_len, write ram[0], wcnt = 1, clear addr_err.
  - Next state is PRIME if n_len == 1, else FILL.
- FILL: in_ready = 1. Each accepted sample writes ram[wcnt] and increments wcnt. The accept with wcnt == n_reg-1 moves to PRIME. in_valid low holds state. n_len changes are ignored.
- PRIME: in_ready = 0, gen_init = 1 for exactly this cycle. Go to DRAIN if GEN_LAT == 1, else to WAIT with wait counter = GEN_LAT-1.
- WAIT: count down; go to DRAIN at 0.
- DRAIN, cycle k = 0..n_reg-1:
  - Issue read at pi_in.
  - If pi_in >= n_reg: read address forced to 0 and addr_err set (sticky until next block start).
  - rcnt increments each cycle. After k = n_reg-1, go to FLUSH.
- Output pipeline:
  - out_valid is high exactly 1 clock after each DRAIN read. out_data = ram[addr]. out_last accompanies read k = n_reg-1.
  - Total: first out_valid at PRIME+GEN_LAT+1. Exactly n_reg consecutive out_valid cycles, no gaps.
- FLUSH: last output presented; return to IDLE next cycle. in_ready stays 0 until IDLE.
- Latency from last input accept to first output: GEN_LAT+2 clocks.
- Read/write never overlap: reads occur only after FILL completes.
- rst at any point, including mid-FILL or mid-DRAIN: return to IDLE next clock with reset values. A partial block is discarded. The generator is re-initialised only by the next PRIME.
- Widths: counters AW bits. Comparison pi_in >= n_reg is unsigned. out_data holds its last value when out_valid = 0.

Test Plan:
- N=40, f1=3, f2=10. Real generator with pi_x0=0, gamma_x0=13, g=20. Inputs 0..39 -> outputs 0,13,6,19,... = (3x+10x^2) mod 40 for x = 0..39. 40 contiguous out_valid cycles; out_last on 40th; first output GEN_LAT+2 clocks after last accept.
- Same block with in_valid toggling 1-0-1-0 during FILL -> identical output; gen_init pulses once, only after the 40th accept.
- n_len=1, input 0xA5, identity generator -> gen_init the cycle after accept; single output 0xA5 with out_last=1; back to IDLE; busy low after FLUSH.
- n_len=0 and n_len=6145 in IDLE -> cfg_err=1, in_ready=0, no state change; n_len=6144 fill/drain -> 6144 outputs, cfg_err=0.
- Behavioural generator injects pi_in=45 at k=5 with N=40 -> out_data at k=5 = ram[0]. addr_err rises and stays high through IDLE, then clears on next block's first accept.
- rst asserted at k=20 of a 40-sample DRAIN -> next clock: out_valid=0, busy=0, state IDLE. A subsequent full block drains correctly from pi(0).
